// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for the 8-source shared bus mux
// Grants one source at a time, bounds hold time, and inserts a dead cycle between owners.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       bus_busy
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [2:0] last_owner_q, last_owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic [7:0] others;
  logic       release_now;

  // Scan starts just past the previous owner so it ends up with lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_owner_q + 3'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    others      = req & ~grant_q;
    release_now = !req[sel_q] || ((hold_cnt_q == MAX_HOLD_C) && (|others));
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = 8'h00;
        busy_d  = 1'b0;
        if (found) begin
          grant_d    = 8'h01 << winner;
          sel_d      = winner;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd1;
          state_d    = OWN;
        end
      end
      OWN: begin
        if (release_now) begin
          grant_d      = 8'h00;
          busy_d       = 1'b0;
          last_owner_d = sel_q;
          hold_cnt_d   = 8'd0;
          state_d      = IDLE;
        end else if (hold_cnt_q != MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 8'h00;
      sel_q        <= 3'd0;
      busy_q       <= 1'b0;
      last_owner_q <= 3'd7;
      hold_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
// Integer-level reference model compared every cycle, plus directed literal checks.
module tb_bus_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       bus_busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bus_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  // Reference model: owner is -1 when the bus is idle.
  int m_owner = -1;
  int m_hold  = 0;
  int m_last  = 7;
  int m_sel   = 0;

  always @(posedge clk) begin
    int o, h, l, s, cand;
    o = m_owner; h = m_hold; l = m_last; s = m_sel;
    if (!rst_n) begin
      o = -1; h = 0; l = 7; s = 0;
    end else if (o < 0) begin
      for (int i = 1; i <= 8; i++) begin
        cand = (l + i) % 8;
        if (o < 0 && req[cand]) begin
          o = cand; s = cand; h = 1;
        end
      end
    end else begin
      if (!req[o] || (h == MH && (req & ~(8'h01 << o)) != 8'h00)) begin
        l = o; o = -1; h = 0;
      end else if (h < MH) begin
        h = h + 1;
      end
    end
    m_owner <= o; m_hold <= h; m_last <= l; m_sel <= s;
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    if (cmp_en) begin
      eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      checks++;
      if (grant !== eg || sel !== 3'(m_sel) || bus_busy !== (m_owner >= 0)) begin
        errors++;
        $display("FAIL model t=%0t grant %h/%h sel %0d/%0d busy %b/%b (got/exp)",
                 $time, grant, eg, sel, m_sel, bus_busy, (m_owner >= 0));
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    tick(2);
    cmp_en = 1'b1;
    chk("reset_grant", grant, 8'h00);
    chk("reset_sel", 8'(sel), 8'h00);
    chk("reset_busy", 8'(bus_busy), 8'h00);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_grant", grant, 8'h00);
      chk("idle_sel", 8'(sel), 8'h00);
      chk("idle_busy", 8'(bus_busy), 8'h00);
    end

    // 2: basic grant and handover
    req = 8'h05;
    tick(1);
    chk("t2_grant0", grant, 8'h01);
    chk("t2_sel0", 8'(sel), 8'h00);
    tick(2);
    req = 8'h04;
    tick(1);
    chk("t2_gap", grant, 8'h00);
    tick(1);
    chk("t2_grant2", grant, 8'h04);
    chk("t2_sel2", 8'(sel), 8'h02);
    req = 8'h00;
    tick(3);

    // 3: rotation with all requesting
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < MH; c++) begin
        tick(1);
        chk("t3_grant", grant, 8'h01 << (g % 8));
        chk("t3_sel", 8'(sel), 8'(g % 8));
      end
      tick(1);
      chk("t3_gap", grant, 8'h00);
    end

    // 4: sole requester saturates and holds
    req = 8'h08;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("t4_grant", grant, 8'h08);
      chk("t4_sel", 8'(sel), 8'h03);
    end
    req = 8'h48;
    tick(1);
    chk("t4_gap", grant, 8'h00);
    tick(1);
    chk("t4_grant6", grant, 8'h40);

    // 5: reset during ownership
    req = 8'h10;
    tick(2);
    chk("t5_own4", grant, 8'h10);
    rst_n = 1'b0;
    tick(1);
    chk("t5_rst_grant", grant, 8'h00);
    chk("t5_rst_sel", 8'(sel), 8'h00);
    chk("t5_rst_busy", 8'(bus_busy), 8'h00);
    rst_n = 1'b1;
    req = 8'h11;
    tick(1);
    chk("t5_grant0", grant, 8'h01);

    // 6: owner drops while another raises on the same edge
    req = 8'h04;
    tick(2);
    chk("t6_own2", grant, 8'h04);
    req = 8'h20;
    tick(1);
    chk("t6_gap", grant, 8'h00);
    tick(1);
    chk("t6_grant5", grant, 8'h20);
    chk("t6_sel5", 8'(sel), 8'h05);
    req = 8'h00;
    tick(4);
    chk("end_idle", grant, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 8-source, 8-bit CPU bus multiplexer. It accepts requests from up to eight bus sources and grants the bus to exactly one at a time. It drives the multiplexer's 3-bit select from the current owner and enforces a bounded hold time so that no source can starve the others. Between owners it always inserts one dead cycle so the bus is never driven by two sources across a handover.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive owned cycles before a forced handover when another source is waiting. Legal range 1..255.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  8  per-source bus request; bit i belongs to source i. Level-sensitive; the source holds it high for as long as it wants the bus.
- `grant`  out  8  one-hot grant, or all-zero when the bus is idle. Registered.
- `sel`  out  3  binary index of the current or most recent owner; connects directly to the multiplexer select. Registered.
- `bus_busy`  out  1  high while any grant bit is high. Registered.

## Operation
Internal state:
- two-state FSM, IDLE and OWN
- `last_owner` (3 bits)
- `hold_cnt` (8 bits, saturating)

Reset (`rst_n`=0 sampled at a rising edge):
- `grant`=0, `sel`=0, `bus_busy`=0
- state=IDLE, `last_owner`=7, `hold_cnt`=0
- Because `last_owner` resets to 7, source 0 has first priority after reset.
- Reset overrides everything, including an active ownership.

IDLE:
- If `req`=0: stay in IDLE; outputs unchanged except `grant`=0 and `bus_busy`=0.
- Otherwise pick the winner by scanning `req` from index `last_owner`+1 upward, wrapping modulo 8. The first set bit wins.
- On the winning edge: `grant`=one-hot(winner), `sel`=winner, `bus_busy`=1, `hold_cnt`=1, state→OWN.

OWN (owner o = `sel`):
- Release: if `req[o]`=0, or if `hold_cnt`==`MAX_HOLD` and any other `req` bit is set, then at that edge:
  - `grant`=0, `bus_busy`=0, `last_owner`=o, `hold_cnt`=0, state→IDLE
  - `sel` keeps the value o.
- Otherwise: stay in OWN, `grant` is unchanged, and `hold_cnt` increments, saturating at `MAX_HOLD`.
- A sole requester keeps the bus indefinitely. Its `hold_cnt` sits at `MAX_HOLD` and it releases only when another request appears or it drops its own request.
- Requests from other sources never alter `grant` during ownership, except through the `MAX_HOLD` rule.

Invariants:
- `grant` is always one-hot or zero.
- `bus_busy` == |`grant`.
- `sel` changes only on a grant edge or at reset.

## Timing
- Request-to-grant latency from IDLE is 1 cycle. A request sampled at edge N produces the grant visible after edge N.
- Release latency is 1 cycle. `req[o]` low sampled at edge N drops `grant` after edge N.
- Handover gap: at least one full cycle with `grant`=0 between any two owners, including when the same source regains the bus.
- A source whose grant is forced off by `MAX_HOLD` and which still requests re-competes in IDLE. It is now `last_owner`, so it has lowest priority.
- If the owner drops `req` and another source raises `req` at the same edge, the release wins. The new source is arbitrated at the next edge.
- Worst-case wait for a continuously requesting source: 7 × (`MAX_HOLD` + 1) + 1 cycles.

## Test plan
1. Reset and idle: hold `rst_n`=0 for 2 cycles, then release it with `req`=0 for 10 cycles → `grant`=0x00, `sel`=0 and `bus_busy`=0 throughout.
2. Basic grant and handover: apply `req`=0x05 → `grant`=0x01 and `sel`=0 one cycle later. Clear `req[0]` after 3 owned cycles → one cycle with `grant`=0x00, then `grant`=0x04 and `sel`=2.
3. Round-robin rotation with `MAX_HOLD`=4 and `req`=0xFF held continuously → `grant` sequence is 0x01, 0x02, …, 0x80, then wraps to 0x01. Each grant lasts exactly 4 cycles and is followed by exactly 1 idle cycle; `sel` is 0..7 in step.
4. Sole requester: apply `req`=0x08 for 40 cycles with `MAX_HOLD`=4 → `grant`=0x08 and `sel`=3 continuously with no gaps. Raise `req[6]` at cycle 40 → `grant`=0x00 for one cycle, then `grant`=0x40.
5. Reset mid-ownership: assert `rst_n`=0 for one edge while `grant`=0x10 → all outputs are 0 after that edge. Then release reset and apply `req`=0x11 → `grant`=0x01 (priority restarts after index 7).
6. Simultaneous release and new request: while the owner is source 2, drop `req[2]` and raise `req[5]` at the same edge → `grant`=0x00 for exactly one cycle, then `grant`=0x20 and `sel`=5.
